// File: rtl/led_breath_pwm_if.sv
// ---------------------------------------------------------------------------
// led_breath_pwm_if
//   Signal bundle between the blink counter / board logic and the LED driver.
//
//   Signals:
//     step_in    : blink toggle from the upstream counter; every edge is one
//                  step event
//     mode       : 0 off, 1 on, 2 follow step_in, 3 breathe
//     led        : registered LED drive
//     state_o    : breathe FSM state (0 IDLE .. 4 HOLD_LOW)
//     cycle_done : one-clk pulse when a breathe cycle wraps back to RAMP_UP
//
//   Handshake: there is no valid/ready pair. step_in is a level that toggles
//   once per step; the consumer detects both edges itself, so the producer
//   never waits and no step can be refused. mode is sampled every clock.
//
//   Modports:
//     master : drives step_in/mode, observes the outputs (upstream / bench)
//     slave  : the LED driver itself
// ---------------------------------------------------------------------------
interface led_breath_pwm_if;
   logic       step_in;
   logic [1:0] mode;
   logic       led;
   logic [2:0] state_o;
   logic       cycle_done;

   modport master (
      output step_in,
      output mode,
      input  led,
      input  state_o,
      input  cycle_done
   );

   modport slave (
      input  step_in,
      input  mode,
      output led,
      output state_o,
      output cycle_done
   );
endinterface

// File: rtl/led_breath_pwm.sv
// ---------------------------------------------------------------------------
// led_breath_pwm
//   LED pin driver sitting after the free-running blink counter. Each edge of
//   the blink toggle is a step event. The LED is driven off, on, following the
//   toggle, or "breathing": a PWM duty that ramps up, holds, ramps down and
//   holds, advancing one step per event.
//
//   Ports:
//     clk    : system clock
//     rst_n  : asynchronous active-low reset
//     bus    : led_breath_pwm_if.slave (step_in, mode, led, state_o,
//              cycle_done)
//
//   Parameters:
//     PWM_BITS   : PWM counter / duty width; period is 2^PWM_BITS clocks
//     STEP       : duty change per step event (1 .. 2^PWM_BITS-1)
//     HOLD_STEPS : step events spent in each hold state (0 = no hold)
//
//   Optional build macro LED_BREATH_GAMMA_EN:
//     defined   - breathe compare uses (duty_eff^2) >> PWM_BITS, registered
//                 once, for a perceptually smoother ramp
//     undefined - linear compare against duty_eff
// ---------------------------------------------------------------------------
module led_breath_pwm #(
   parameter int PWM_BITS   = 8,
   parameter int STEP       = 16,
   parameter int HOLD_STEPS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   led_breath_pwm_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RAMP_UP   = 3'd1,
      S_HOLD_HIGH = 3'd2,
      S_RAMP_DOWN = 3'd3,
      S_HOLD_LOW  = 3'd4
   } state_t;

   localparam int HW = (HOLD_STEPS < 1) ? 1 : $clog2(HOLD_STEPS + 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(STEP);
   localparam logic [HW-1:0]       HOLD_LAST = HW'((HOLD_STEPS < 1) ? 0 : HOLD_STEPS - 1);

   logic                step_q;
   logic [1:0]          mode_q;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] duty_eff;
   logic [PWM_BITS-1:0] duty_cmp;
   logic [HW-1:0]       hold_cnt;
   state_t              state;
   logic                led_r;
   logic                cycle_done_r;

   logic                step_ev;
   logic [PWM_BITS:0]   duty_up_sum;
   logic [PWM_BITS-1:0] duty_up;
   logic [PWM_BITS-1:0] duty_dn;

   // Both edges of the toggle count as a step.
   assign step_ev = bus.step_in ^ step_q;

   // One extra bit on the sum so a large STEP saturates instead of wrapping.
   assign duty_up_sum = {1'b0, duty} + STEP_W;
   assign duty_up     = (duty_up_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX
                                                         : duty_up_sum[PWM_BITS-1:0];
   assign duty_dn     = ({1'b0, duty} > STEP_W) ? (duty - STEP_W[PWM_BITS-1:0])
                                                : '0;

   // Edge history, PWM counter and the period-aligned duty copy.
   // duty_eff only changes at the end of a period so a duty change never
   // produces a runt pulse mid-period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q   <= 1'b0;
         mode_q   <= 2'd0;
         pwm_cnt  <= '0;
         duty_eff <= '0;
      end else begin
         step_q  <= bus.step_in;
         mode_q  <= bus.mode;
         pwm_cnt <= pwm_cnt + 1'b1;
         if (pwm_cnt == DUTY_MAX) begin
            duty_eff <= duty;
         end
      end
   end

`ifdef LED_BREATH_GAMMA_EN
   // Squared duty, scaled back to PWM_BITS. Registered once: it lags duty_eff
   // by a clock, while the led-to-pwm_cnt relationship is unchanged.
   logic [2*PWM_BITS-1:0] duty_sq;
   logic [PWM_BITS-1:0]   duty_g;

   assign duty_sq = {{PWM_BITS{1'b0}}, duty_eff} * {{PWM_BITS{1'b0}}, duty_eff};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_g <= '0;
      end else begin
         duty_g <= duty_sq[2*PWM_BITS-1:PWM_BITS];
      end
   end

   assign duty_cmp = duty_g;
`else
   assign duty_cmp = duty_eff;
`endif

   // LED output register. duty_cmp == 0 keeps the LED dark; the maximum duty
   // leaves it low only on the pwm_cnt == max cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_r <= 1'b0;
      end else begin
         case (bus.mode)
            2'd0:    led_r <= 1'b0;
            2'd1:    led_r <= 1'b1;
            2'd2:    led_r <= bus.step_in;
            default: led_r <= (pwm_cnt < duty_cmp);
         endcase
      end
   end

   // Breathe FSM. Everything outside mode 3 parks in IDLE with duty cleared.
   // The entry cycle into mode 3 restarts the ramp and ignores any step event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         duty         <= '0;
         hold_cnt     <= '0;
         cycle_done_r <= 1'b0;
      end else begin
         cycle_done_r <= 1'b0;
         if (bus.mode != 2'd3) begin
            state    <= S_IDLE;
            duty     <= '0;
            hold_cnt <= '0;
         end else if (mode_q != 2'd3) begin
            state    <= S_RAMP_UP;
            duty     <= '0;
            hold_cnt <= '0;
         end else if (step_ev) begin
            case (state)
               S_RAMP_UP: begin
                  duty <= duty_up;
                  if (duty_up == DUTY_MAX) begin
                     state    <= (HOLD_STEPS == 0) ? S_RAMP_DOWN : S_HOLD_HIGH;
                     hold_cnt <= '0;
                  end
               end
               S_HOLD_HIGH: begin
                  if (hold_cnt == HOLD_LAST) begin
                     state    <= S_RAMP_DOWN;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               S_RAMP_DOWN: begin
                  duty <= duty_dn;
                  if (duty_dn == '0) begin
                     hold_cnt <= '0;
                     if (HOLD_STEPS == 0) begin
                        state        <= S_RAMP_UP;
                        cycle_done_r <= 1'b1;
                     end else begin
                        state <= S_HOLD_LOW;
                     end
                  end
               end
               S_HOLD_LOW: begin
                  if (hold_cnt == HOLD_LAST) begin
                     state        <= S_RAMP_UP;
                     hold_cnt     <= '0;
                     cycle_done_r <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               default: begin
                  state    <= S_RAMP_UP;
                  duty     <= '0;
                  hold_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign bus.led        = led_r;
   assign bus.state_o    = state;
   assign bus.cycle_done = cycle_done_r;

endmodule

// File: tb/tb_led_breath_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_breath_pwm
//   Two LED drivers (PWM_BITS=4, STEP=4) share clock, reset and inputs:
//   dut_a holds 2 step events in each hold state, dut_b has no hold.
//   A reference model built from the breathe rules (the sequence of
//   state/duty values a breathe cycle walks through, indexed by the number of
//   step events since mode 3 was entered) predicts led, state_o and
//   cycle_done every clock.
// ---------------------------------------------------------------------------
module tb_led_breath_pwm;

   localparam int PB   = 4;
   localparam int ST   = 4;
   localparam int MAXV = (1 << PB) - 1;

   // ---------------- clock / reset -----------------------------------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic       step_in;
   logic [1:0] mode;

   always #5 clk = ~clk;

   led_breath_pwm_if bus_a ();
   led_breath_pwm_if bus_b ();

   assign bus_a.step_in = step_in;
   assign bus_a.mode    = mode;
   assign bus_b.step_in = step_in;
   assign bus_b.mode    = mode;

   led_breath_pwm #(.PWM_BITS(PB), .STEP(ST), .HOLD_STEPS(2)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   led_breath_pwm #(.PWM_BITS(PB), .STEP(ST), .HOLD_STEPS(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   // ---------------- scoreboard --------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
   endtask

   // expected {state[2:0], cycle_done, led} per DUT
   logic [4:0] exp_q_a[$];
   logic [4:0] exp_q_b[$];

   // ---------------- reference model ---------------------------------------
   int hold_of[2] = '{2, 0};
   int seq_st[2][64];
   int seq_du[2][64];
   int seq_dn[2][64];
   int seq_len[2];

   // Outcome (state, duty, cycle_done) of each step event of one breathe
   // cycle; after the last entry the cycle is back at RAMP_UP with duty 0.
   function automatic void build_seq(input int k);
      int h = hold_of[k];
      int d = 0;
      int n = 0;
      while (1) begin
         d = d + ST;
         if (d > MAXV) d = MAXV;
         seq_st[k][n] = (d == MAXV) ? ((h > 0) ? 2 : 3) : 1;
         seq_du[k][n] = d; seq_dn[k][n] = 0; n++;
         if (d == MAXV) break;
      end
      for (int i = 1; i <= h; i++) begin
         seq_st[k][n] = (i == h) ? 3 : 2; seq_du[k][n] = MAXV; seq_dn[k][n] = 0; n++;
      end
      while (1) begin
         d = d - ST;
         if (d < 0) d = 0;
         seq_st[k][n] = (d == 0) ? ((h > 0) ? 4 : 1) : 3;
         seq_du[k][n] = d; seq_dn[k][n] = (d == 0 && h == 0) ? 1 : 0; n++;
         if (d == 0) break;
      end
      for (int i = 1; i <= h; i++) begin
         seq_st[k][n] = (i == h) ? 1 : 4; seq_du[k][n] = 0; seq_dn[k][n] = (i == h) ? 1 : 0; n++;
      end
      seq_len[k] = n;
   endfunction

   int m_pwm, m_prev_step, m_prev_mode;
   int m_pos[2], m_state[2], m_duty[2], m_done[2], m_led[2], m_eff[2], m_g[2];

   task automatic model_reset();
      m_pwm = 0; m_prev_step = 0; m_prev_mode = 0;
      for (int k = 0; k < 2; k++) begin
         m_pos[k] = -1; m_state[k] = 0; m_duty[k] = 0; m_done[k] = 0;
         m_led[k] = 0; m_eff[k] = 0; m_g[k] = 0;
      end
   endtask

   // One clock edge using the inputs present at that edge.
   task automatic model_step();
      int ev;
      int cmp;
      int idx;
      ev = (int'(step_in) != m_prev_step) ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
`ifdef LED_BREATH_GAMMA_EN
         cmp = m_g[k];
`else
         cmp = m_eff[k];
`endif
         case (mode)
            2'd0:    m_led[k] = 0;
            2'd1:    m_led[k] = 1;
            2'd2:    m_led[k] = int'(step_in);
            default: m_led[k] = (m_pwm < cmp) ? 1 : 0;
         endcase
         m_g[k] = (m_eff[k] * m_eff[k]) >> PB;
         if (m_pwm == MAXV) m_eff[k] = m_duty[k];
         m_done[k] = 0;
         if (mode != 2'd3) begin
            m_pos[k] = -1; m_state[k] = 0; m_duty[k] = 0;
         end else if (m_prev_mode != 3) begin
            m_pos[k] = 0; m_state[k] = 1; m_duty[k] = 0;
         end else if (ev == 1 && m_pos[k] >= 0) begin
            m_pos[k]++;
            idx = (m_pos[k] - 1) % seq_len[k];
            m_state[k] = seq_st[k][idx];
            m_duty[k]  = seq_du[k][idx];
            m_done[k]  = seq_dn[k][idx];
         end
      end
      m_pwm       = (m_pwm + 1) % (MAXV + 1);
      m_prev_step = int'(step_in);
      m_prev_mode = int'(mode);
   endtask

   // ---------------- driver tasks ------------------------------------------
   int cnt_done_a  = 0;
   int cnt_done_b  = 0;
   int saw_hold_b  = 0;

   task automatic compare_all();
      logic [4:0] ea;
      logic [4:0] eb;
      ea = exp_q_a.pop_front();
      eb = exp_q_b.pop_front();
      check("a_led",   8'(bus_a.led),        8'(ea[0]));
      check("a_done",  8'(bus_a.cycle_done), 8'(ea[1]));
      check("a_state", 8'(bus_a.state_o),    8'(ea[4:2]));
      check("b_led",   8'(bus_b.led),        8'(eb[0]));
      check("b_done",  8'(bus_b.cycle_done), 8'(eb[1]));
      check("b_state", 8'(bus_b.state_o),    8'(eb[4:2]));
      if (bus_a.cycle_done) cnt_done_a++;
      if (bus_b.cycle_done) cnt_done_b++;
      if (bus_b.state_o == 3'd2 || bus_b.state_o == 3'd4) saw_hold_b = 1;
   endtask

   // Advance one clock: model the edge, then compare on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      exp_q_a.push_back({3'(m_state[0]), 1'(m_done[0]), 1'(m_led[0])});
      exp_q_b.push_back({3'(m_state[1]), 1'(m_done[1]), 1'(m_led[1])});
      @(negedge clk);
      compare_all();
   endtask

   task automatic step_wait(input int gap);
      step_in = ~step_in;
      repeat (gap) tick();
   endtask

   // Assert reset between clock edges and check the immediate effect.
   task automatic async_reset(input int cycles);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_led_a",   8'(bus_a.led),     8'd0);
      check("async_state_a", 8'(bus_a.state_o), 8'd0);
      check("async_led_b",   8'(bus_b.led),     8'd0);
      repeat (cycles) tick();
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------------------------------------
   int hi_cnt;

   initial begin
      build_seq(0);
      build_seq(1);
      rst_n   = 1'b0;
      mode    = 2'd1;
      step_in = 1'b0;
      model_reset();

      // reset held with mode 1 and a toggling step input
      for (int i = 0; i < 5; i++) begin
         step_in = ~step_in;
         tick();
      end
      rst_n = 1'b1;
      repeat (2) tick();
      check("post_rst_led", 8'(bus_a.led), 8'd1);

      // static modes
      mode = 2'd2; step_in = 1'b0; tick();
      step_in = 1'b1; tick();
      check("m2_led", 8'(bus_a.led), 8'd1);
      mode = 2'd0; tick();
      check("m0_led", 8'(bus_a.led), 8'd0);
      mode = 2'd1; tick();
      check("m1_led", 8'(bus_a.led), 8'd1);

      // one step into breathe -> duty 4, measure one full period
      mode = 2'd3; tick();
      step_wait(1);
      repeat (40) tick();
      hi_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (bus_a.led) hi_cnt++;
      end
`ifdef LED_BREATH_GAMMA_EN
      check("pwm_hi_cnt", 8'(hi_cnt), 8'd1);
`else
      check("pwm_hi_cnt", 8'(hi_cnt), 8'd4);
`endif

      // rest of one full breathe cycle for dut_a (12 events in total)
      cnt_done_a = 0; cnt_done_b = 0; saw_hold_b = 0;
      for (int i = 0; i < 11; i++) step_wait(3);
      check("cycle_state_a", 8'(bus_a.state_o), 8'd1);
      check("cycle_done_a",  8'(cnt_done_a),    8'd1);
      check("cycle_done_b",  8'(cnt_done_b),    8'd1);
      check("b_state_now",   8'(bus_b.state_o), 8'd3);
      check("b_no_hold",     8'(saw_hold_b),    8'd0);

      // leave breathe mid ramp-down, then come back
      for (int i = 0; i < 40 && m_state[0] != 3; i++) step_wait(2);
      check("ramp_down_reached", 8'(bus_a.state_o), 8'd3);
      mode = 2'd1; tick();
      check("intr_state", 8'(bus_a.state_o), 8'd0);
      check("intr_led",   8'(bus_a.led),     8'd1);
      mode = 2'd3; tick();
      check("reentry_state", 8'(bus_a.state_o), 8'd1);
      step_wait(2);
      step_wait(2);
      async_reset(2);
      tick();

      // randomized run
      mode = 2'd3;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) step_in = ~step_in;
         if ($urandom_range(0, 399) == 0) mode = 2'($urandom_range(0, 3));
         else if (mode != 2'd3 && $urandom_range(0, 49) == 0) mode = 2'd3;
         if ($urandom_range(0, 1499) == 0) async_reset($urandom_range(1, 3));
         tick();
      end
      // fast stepping: an event every clock
      mode = 2'd3;
      for (int i = 0; i < 200; i++) begin
         step_in = ~step_in;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
